five_bit_or: RTL and testbench
==============================

FIVE_BIT_OR -- requirements
Module: five_bit_or

Interface
REQ-001 SHALL provide parameter MASK_RESET, default 5'b11111: mask register value after reset.
REQ-002 SHALL use one clock and a synchronous, active-high reset; no other clock or reset.
REQ-003 Port list, one per line, clock and reset first:
  clk  input  1  rising-edge clock;
  rst  input  1  synchronous active-high reset;
  inp  input  5  data vector;
  in_valid  input  1  inp qualifier for registered path;
  mask_wr  input  1  load mask_in into mask register;
  mask_in  input  5  new mask value;
  clr  input  1  clear sticky flag;
  out  output  1  combinational OR of all inp bits;
  out_q  output  1  registered OR of masked inp;
  out_vld  output  1  out_q/lsb_idx/popcnt updated this cycle;
  lsb_idx  output  3  index of lowest set masked bit, 3'd7 if none;
  popcnt  output  3  count of set masked bits (0..5);
  mask  output  5  current mask register;
  sticky  output  1  accumulated OR since last clr/reset.

Function
REQ-004 out SHALL equal inp[0]|inp[1]|inp[2]|inp[3]|inp[4], combinational, zero latency, unmasked, independent of clk, rst, in_valid.
REQ-005 Masked vector m SHALL be inp & mask (mask = register value before the current edge).
REQ-006 On a rising edge with in_valid=1: out_q <= |m; lsb_idx <= lowest i with m[i]=1, else 3'd7; popcnt <= number of ones in m.
REQ-007 With in_valid=0: out_q, lsb_idx, popcnt SHALL hold.
REQ-008 out_vld SHALL be in_valid delayed one cycle; one-cycle latency, no backpressure.
REQ-009 On a rising edge with mask_wr=1: mask <= mask_in; same-cycle in_valid uses the old mask.
REQ-010 sticky (when compiled in): clr=1 -> sticky <= in_valid & |m; else sticky <= sticky | (in_valid & |m); a same-cycle set wins over clr.
REQ-011 m = 5'b00000 with in_valid=1 SHALL give out_q=0, lsb_idx=7, popcnt=0.
REQ-012 All 32 inp values SHALL be handled; no X propagation from unused states.

Reset
REQ-013 On a rising edge with rst=1: out_q=0, out_vld=0, lsb_idx=3'd7, popcnt=0, mask=MASK_RESET, sticky=0; rst overrides in_valid, mask_wr and clr.
REQ-014 out SHALL keep following inp during reset.
REQ-015 Reset asserted mid-stream SHALL discard the in-flight sample; out_vld=0 in the cycle after reset.

Configuration
REQ-016 Macro FIVE_BIT_OR_STICKY_EN defined: sticky register and clr function per REQ-010.
REQ-017 Macro undefined: no sticky register; sticky tied to 0; clr ignored; all other behaviour unchanged.

Structure
REQ-018 Package five_bit_or_pkg SHALL hold DATA_W=5, IDX_W=3, CNT_W=3, IDX_NONE=3'd7, and a typedef for the 5-bit data vector.
REQ-019 Lowest-set-bit encoder SHALL be a sub-module five_bit_lsb_enc (5-bit in, 3-bit index, 3'd7 when zero, combinational); popcount stays inline.

Verification
REQ-020 inp=5'b00000 held 10 ns -> out=0; with in_valid=1 next cycle out_q=0, lsb_idx=7, popcnt=0.
REQ-021 inp=5'b00001 -> out=1 combinationally; registered: out_q=1, lsb_idx=0, popcnt=1.
REQ-022 inp=5'b00100 -> out=1; registered: out_q=1, lsb_idx=2, popcnt=1; inp=5'b11010 -> lsb_idx=1, popcnt=3.
REQ-023 mask_wr=1, mask_in=5'b11000, same cycle in_valid=1, inp=5'b00011 -> out_q=1 (old mask); next sample inp=5'b00011 -> out_q=0, out=1, lsb_idx=7.
REQ-024 With FIVE_BIT_OR_STICKY_EN: inp=5'b10000 valid -> sticky=1; inp=0 valid -> sticky stays 1; clr=1 with inp=0 -> sticky=0; clr=1 with inp=5'b00001 valid -> sticky=1.
REQ-025 rst=1 while in_valid=1, inp=5'b11111 -> after edge out_vld=0, out_q=0, lsb_idx=7, mask=MASK_RESET, out=1.

Source files
------------

// File: rtl/five_bit_or_pkg.sv
// Shared widths, sentinel values and the data vector type for the five_bit_or block.
package five_bit_or_pkg;
    localparam int DATA_W = 5;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 3;
    localparam logic [IDX_W-1:0] IDX_NONE = 3'd7;

    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/five_bit_or_lsb_enc.sv
// Lowest-set-bit encoder: index of the lowest one in a 5-bit vector, IDX_NONE when zero.
// Latency: combinational, zero cycles.
// Backpressure: none.
module five_bit_lsb_enc
    import five_bit_or_pkg::*;
(
    input  data_t            vec,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = IDX_NONE;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/five_bit_or.sv
// Five-bit OR: combinational OR of inp plus registered masked OR/lsb/popcount; sticky flag with FIVE_BIT_OR_STICKY_EN.
// Latency: out is combinational; out_q/lsb_idx/popcnt/out_vld one cycle after in_valid.
// Backpressure: none, every valid sample is accepted.
module five_bit_or
    import five_bit_or_pkg::*;
#(
    parameter data_t MASK_RESET = 5'b11111
) (
    input  logic             clk,
    input  logic             rst,
    input  data_t            inp,
    input  logic             in_valid,
    input  logic             mask_wr,
    input  data_t            mask_in,
    input  logic             clr,
    output logic             out,
    output logic             out_q,
    output logic             out_vld,
    output logic [IDX_W-1:0] lsb_idx,
    output logic [CNT_W-1:0] popcnt,
    output data_t            mask,
    output logic             sticky
);

    data_t            masked;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

    assign out    = |inp;
    // The register value ahead of the edge applies, so a same-cycle mask_wr only affects later samples.
    assign masked = inp & mask;
    assign hit    = in_valid & (|masked);

    five_bit_lsb_enc u_lsb_enc (
        .vec (masked),
        .idx (idx_nxt)
    );

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(masked[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= 1'b0;
            out_vld <= 1'b0;
            lsb_idx <= IDX_NONE;
            popcnt  <= '0;
            mask    <= MASK_RESET;
        end else begin
            out_vld <= in_valid;
            if (in_valid) begin
                out_q   <= |masked;
                lsb_idx <= idx_nxt;
                popcnt  <= cnt_nxt;
            end
            if (mask_wr) begin
                mask <= mask_in;
            end
        end
    end

`ifdef FIVE_BIT_OR_STICKY_EN
    // A hit in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= 1'b0;
        end else if (clr) begin
            sticky <= hit;
        end else begin
            sticky <= sticky | hit;
        end
    end
`else
    logic unused_sticky_in;
    assign unused_sticky_in = clr ^ hit;
    assign sticky           = 1'b0;
`endif

endmodule

// File: tb/tb_five_bit_or.sv
// Directed, table-driven bench for five_bit_or; sticky expectations follow FIVE_BIT_OR_STICKY_EN.
module tb_five_bit_or;

`ifdef FIVE_BIT_OR_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] inp;
    logic       in_valid;
    logic       mask_wr;
    logic [4:0] mask_in;
    logic       clr;
    logic       out;
    logic       out_q;
    logic       out_vld;
    logic [2:0] lsb_idx;
    logic [2:0] popcnt;
    logic [4:0] mask;
    logic       sticky;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    five_bit_or dut (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .in_valid (in_valid),
        .mask_wr  (mask_wr),
        .mask_in  (mask_in),
        .clr      (clr),
        .out      (out),
        .out_q    (out_q),
        .out_vld  (out_vld),
        .lsb_idx  (lsb_idx),
        .popcnt   (popcnt),
        .mask     (mask),
        .sticky   (sticky)
    );

    typedef struct {
        logic [4:0] inp;
        logic       exp_out;
        logic       exp_q;
        logic [2:0] exp_idx;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input int q, input int idx, input int cnt);
        chk({tag, ".out_q"}, out_q, q);
        chk({tag, ".lsb_idx"}, lsb_idx, idx);
        chk({tag, ".popcnt"}, popcnt, cnt);
    endtask

    initial begin
        vecs[0] = '{5'b00000, 1'b0, 1'b0, 3'd7, 3'd0};
        vecs[1] = '{5'b00001, 1'b1, 1'b1, 3'd0, 3'd1};
        vecs[2] = '{5'b00100, 1'b1, 1'b1, 3'd2, 3'd1};
        vecs[3] = '{5'b11010, 1'b1, 1'b1, 3'd1, 3'd3};
        vecs[4] = '{5'b11111, 1'b1, 1'b1, 3'd0, 3'd5};
        vecs[5] = '{5'b10000, 1'b1, 1'b1, 3'd4, 3'd1};
        vecs[6] = '{5'b01100, 1'b1, 1'b1, 3'd2, 3'd2};
        vecs[7] = '{5'b10101, 1'b1, 1'b1, 3'd0, 3'd3};

        rst = 1'b1; inp = 5'b00100; in_valid = 1'b0;
        mask_wr = 1'b0; mask_in = 5'b00000; clr = 1'b0;
        tick();
        tick();
        chk_reg("reset", 0, 7, 0);
        chk("reset.out_vld", out_vld, 0);
        chk("reset.mask", mask, 5'b11111);
        chk("reset.sticky", sticky, 0);
        chk("reset.out_follows", out, 1);
        inp = 5'b00000;
        #1;
        chk("reset.out_follows0", out, 0);

        rst = 1'b0;
        tick();

        // Main function: all with default mask 11111.
        for (int i = 0; i < 8; i++) begin
            inp = vecs[i].inp;
            in_valid = 1'b1;
            #8;
            chk($sformatf("vec%0d.out", i), out, vecs[i].exp_out);
            tick();
            chk($sformatf("vec%0d.out_vld", i), out_vld, 1);
            chk_reg($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_idx, vecs[i].exp_cnt);
        end

        // Hold with in_valid low: registered outputs keep 10101 results.
        in_valid = 1'b0; inp = 5'b01000;
        tick();
        chk("hold.out_vld", out_vld, 0);
        chk_reg("hold", 1, 0, 3);
        chk("hold.out", out, 1);

        // Same-cycle mask write uses the old mask.
        mask_wr = 1'b1; mask_in = 5'b11000; in_valid = 1'b1; inp = 5'b00011;
        tick();
        chk_reg("maskold", 1, 0, 2);
        chk("maskold.mask", mask, 5'b11000);
        mask_wr = 1'b0;
        tick();
        chk_reg("masknew", 0, 7, 0);
        chk("masknew.out", out, 1);
        inp = 5'b11010;
        tick();
        chk_reg("masknew2", 1, 3, 2);

        mask_wr = 1'b1; mask_in = 5'b11111; in_valid = 1'b0;
        tick();
        mask_wr = 1'b0;
        chk("maskrestore", mask, 5'b11111);

        // Sticky sequence.
        clr = 1'b1; in_valid = 1'b0;
        tick();
        chk("stk.clear0", sticky, 0);
        clr = 1'b0; in_valid = 1'b1; inp = 5'b10000;
        tick();
        chk("stk.set", sticky, STK ? 1 : 0);
        inp = 5'b00000;
        tick();
        chk("stk.hold", sticky, STK ? 1 : 0);
        chk_reg("zero", 0, 7, 0);
        clr = 1'b1;
        tick();
        chk("stk.clr", sticky, 0);
        inp = 5'b00001;
        tick();
        chk("stk.setwins", sticky, STK ? 1 : 0);
        clr = 1'b0;

        // Reset mid-stream overrides valid sample and mask write.
        rst = 1'b1; in_valid = 1'b1; inp = 5'b11111;
        mask_wr = 1'b1; mask_in = 5'b00000; clr = 1'b0;
        tick();
        chk("rstmid.out_vld", out_vld, 0);
        chk_reg("rstmid", 0, 7, 0);
        chk("rstmid.mask", mask, 5'b11111);
        chk("rstmid.sticky", sticky, 0);
        chk("rstmid.out", out, 1);
        rst = 1'b0; in_valid = 1'b0; mask_wr = 1'b0;
        tick();
        chk("postrst.out_vld", out_vld, 0);
        chk_reg("postrst", 0, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
